// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer with start detect, 3-sample majority vote and parity/stop checks
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 3,
  parameter int BIT_CNT_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  output logic [COUNTER_WIDTH-1:0] edg_cnt,
  output logic [BIT_CNT_WIDTH-1:0] bit_cnt,
  output logic                     deser_en,
  output logic                     sampled_bit,
  output logic                     par_err,
  output logic                     stp_err,
  output logic                     strt_glitch,
  output logic                     data_valid
);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] MID = COUNTER_WIDTH'(2 ** (COUNTER_WIDTH - 1));
  localparam logic [BIT_CNT_WIDTH-1:0] LAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [BIT_CNT_WIDTH-1:0] bit_q, bit_d;
  logic s0_q, s0_d, s1_q, s1_d, sb_q, sb_d, acc_q, acc_d, pe_q, pe_d, pt_q, pt_d;
  logic perr_q, perr_d, serr_q, serr_d, glitch_q, glitch_d, dv_q, dv_d, den_q, den_d;
  logic end_bit, maj;
  assign end_bit = cnt_q == CNT_MAX;
  assign maj     = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
  // cnt_q is 0 in IDLE and MID-1 >= 1, so sampling never fires while idle
  always_comb begin
    state_d  = state_q;
    cnt_d    = state_q == IDLE ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    s0_d     = cnt_q == MID - 1'b1 ? RX_IN : s0_q;
    s1_d     = cnt_q == MID ? RX_IN : s1_q;
    sb_d     = cnt_q == MID + 1'b1 ? maj : sb_q;
    acc_d    = acc_q;
    pe_d     = pe_q;
    pt_d     = pt_q;
    perr_d   = perr_q;
    serr_d   = serr_q;
    glitch_d = 1'b0;
    dv_d     = 1'b0;
    case (state_q)
      IDLE: if (!RX_IN) begin
        state_d = START;
        pe_d    = PAR_EN;
        pt_d    = PAR_TYP;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
        acc_d   = 1'b0;
      end
      START: if (end_bit) begin
        state_d  = sb_q ? IDLE : DATA;
        glitch_d = sb_q;
        bit_d    = '0;
      end
      DATA: if (end_bit) begin
        acc_d   = acc_q ^ sb_q;
        state_d = bit_q == LAST ? (pe_q ? PARITY : STOP) : DATA;
        bit_d   = bit_q == LAST ? '0 : bit_q + 1'b1;
      end
      PARITY: if (end_bit) begin
        perr_d  = sb_q ^ acc_q ^ pt_q;
        state_d = STOP;
      end
      STOP: if (end_bit) begin
        serr_d  = ~sb_q;
        dv_d    = ~perr_q & sb_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    den_d = state_d == DATA;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      sb_q     <= 1'b1;
      acc_q    <= 1'b0;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      glitch_q <= 1'b0;
      dv_q     <= 1'b0;
      den_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      pe_q     <= pe_d;
      pt_q     <= pt_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      glitch_q <= glitch_d;
      dv_q     <= dv_d;
      den_q    <= den_d;
    end
  end
  assign edg_cnt     = cnt_q;
  assign bit_cnt     = bit_q;
  assign deser_en    = den_q;
  assign sampled_bit = sb_q;
  assign par_err     = perr_q;
  assign stp_err     = serr_q;
  assign strt_glitch = glitch_q;
  assign data_valid  = dv_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: waveform-table stimulus with a frame-timing model checked every cycle
module tb_uart_rx_ctrl;
  localparam int NMAX = 1024;
  logic       CLK = 0, RST = 1, RX_IN = 1, PAR_EN = 0, PAR_TYP = 0;
  logic [2:0] edg_cnt;
  logic [3:0] bit_cnt;
  logic       deser_en, sampled_bit, par_err, stp_err, strt_glitch, data_valid;

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .edg_cnt(edg_cnt), .bit_cnt(bit_cnt), .deser_en(deser_en), .sampled_bit(sampled_bit),
    .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch), .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  bit         w_rx[NMAX], w_rst[NMAX], w_pe[NMAX], w_pt[NMAX];
  int         x_edg[NMAX+1], x_bc[NMAX+1], x_byte[NMAX+1];
  bit         x_den[NMAX+1], x_sb[NMAX+1], x_perr[NMAX+1], x_serr[NMAX+1], x_gl[NMAX+1], x_dv[NMAX+1];
  int         len = 0, checks = 0, errors = 0, ecount = 0, dut_dv = 0;
  logic [7:0] p_data = 8'h00;

  // reference deserializer: shifts LSB-first on the last edge of each data bit
  always @(posedge CLK) begin
    ecount <= ecount + 1;
    if (deser_en && edg_cnt == 3'd7) p_data <= {sampled_bit, p_data[7:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, ecount, act, exp);
    end
  endtask

  task automatic emit(input bit rx, input bit pe, input bit pt, input bit rst);
    w_rx[len] = rx; w_pe[len] = pe; w_pt[len] = pt; w_rst[len] = rst;
    len++;
  endtask

  task automatic idle(input int n);
    repeat (n) emit(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // one frame of 8-clock bits; flip_k forces the edg_cnt=4 sample of bit k low; cut truncates with a reset
  task automatic frame(input logic [7:0] d, input bit pe, input bit pt, input bit pbit, input bit stop,
                       input int flip_k, input int cut, output int s);
    bit fb[11];
    int nb;
    s = len;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = d[i];
    nb = 9;
    if (pe) begin fb[9] = pbit; nb = 10; end
    fb[nb] = stop;
    nb++;
    for (int i = 0; i < nb * 8 && i < cut; i++)
      emit(fb[i/8], i == 0 ? pe : !pe, i == 0 ? pt : !pt, i == cut - 1);
    if (flip_k >= 0) w_rx[s + 8 * flip_k + 5] = 1'b0;
  endtask

  function automatic bit vote(input int s, input int k);
    int c;
    c = s + 8 * k + 4;
    return (w_rx[c] & w_rx[c+1]) | (w_rx[c] & w_rx[c+2]) | (w_rx[c+1] & w_rx[c+2]);
  endfunction

  function automatic logic [7:0] rx_byte(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = vote(s, i + 1);
    return b;
  endfunction

  // frame model: bit k of a frame detected at edge s spans edges s+1+8k .. s+8+8k
  task automatic build_model;
    bit busy = 0, pe = 0, pt = 0, perr = 0, serr = 0, sb = 1, gl, dv;
    int s = 0, n, k, m, last;
    for (int e = 0; e < len; e++) begin
      gl = 0; dv = 0;
      x_byte[e+1] = 0;
      if (w_rst[e]) begin
        busy = 0; perr = 0; serr = 0; sb = 1;
      end else if (!busy) begin
        if (!w_rx[e]) begin
          busy = 1; s = e; pe = w_pe[e]; pt = w_pt[e]; perr = 0; serr = 0;
        end
      end else begin
        n = e - s - 1;
        k = n / 8;
        last = pe ? 10 : 9;
        if (n % 8 == 5) sb = vote(s, k);
        if (n % 8 == 7) begin
          if (k == 0 && sb) begin
            gl = 1; busy = 0;
          end else if (pe && k == 9) begin
            perr = sb ^ (^rx_byte(s)) ^ pt;
          end else if (k == last) begin
            serr = !sb;
            dv = !perr && sb;
            if (dv) x_byte[e+1] = int'(rx_byte(s));
            busy = 0;
          end
        end
      end
      m = e - s;
      x_edg[e+1]  = busy ? m % 8 : 0;
      x_den[e+1]  = busy && m / 8 >= 1 && m / 8 <= 8;
      x_bc[e+1]   = x_den[e+1] ? m / 8 - 1 : 0;
      x_sb[e+1]   = sb;
      x_perr[e+1] = perr;
      x_serr[e+1] = serr;
      x_gl[e+1]   = gl;
      x_dv[e+1]   = dv;
    end
  endtask

  function automatic int first_dv(input int s);
    for (int c = s; c <= len; c++) if (x_dv[c]) return c;
    return -1;
  endfunction

  function automatic int den_count(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(x_den[c]);
    return n;
  endfunction

  always @(negedge CLK) begin
    if (ecount >= 1 && ecount <= len) begin
      check("edg_cnt", 32'(edg_cnt), x_edg[ecount]);
      check("bit_cnt", 32'(bit_cnt), x_bc[ecount]);
      check("deser_en", 32'(deser_en), 32'(x_den[ecount]));
      check("sampled_bit", 32'(sampled_bit), 32'(x_sb[ecount]));
      check("par_err", 32'(par_err), 32'(x_perr[ecount]));
      check("stp_err", 32'(stp_err), 32'(x_serr[ecount]));
      check("strt_glitch", 32'(strt_glitch), 32'(x_gl[ecount]));
      check("data_valid", 32'(data_valid), 32'(x_dv[ecount]));
      if (x_dv[ecount]) check("p_data", 32'(p_data), x_byte[ecount]);
      if (data_valid === 1'b1) dut_dv++;
    end
  end

  initial begin
    int s1, s2a, s2b, s3, sg, s5, s5b, s6, s6b, ndv;
    emit(1'b1, 1'b0, 1'b0, 1'b1);
    emit(1'b1, 1'b0, 1'b0, 1'b1);
    idle(8);
    frame(8'hA5, 0, 0, 0, 1, -1, 1000, s1);  idle(4);
    frame(8'h3C, 1, 0, 0, 1, -1, 1000, s2a); idle(4);
    frame(8'h3C, 1, 0, 1, 1, -1, 1000, s2b); idle(4);
    frame(8'h01, 1, 1, 0, 0, -1, 1000, s3);  idle(4);
    sg = len;
    emit(1'b0, 1'b0, 1'b0, 1'b0);
    emit(1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);
    frame(8'h66, 0, 0, 0, 1, 2, 1000, s5);
    frame(8'hC3, 1, 1, 1, 1, -1, 1000, s5b); idle(4);
    frame(8'h5A, 0, 0, 0, 1, -1, 36, s6);    idle(5);
    frame(8'h5A, 0, 0, 0, 1, -1, 1000, s6b); idle(10);
    build_model;
    check("pin_latency_par", first_dv(s2a) - s2a, 89);
    check("pin_latency_nopar", first_dv(s1) - s1, 81);
    check("pin_byte_a5", x_byte[s1+81], 32'h A5);
    check("pin_den_cycles", den_count(s1, s1 + 90), 64);
    check("pin_perr", 32'(x_perr[s2b+89]), 1);
    check("pin_no_dv_perr", 32'(x_dv[s2b+89]), 0);
    check("pin_serr", 32'(x_serr[s3+89]), 1);
    check("pin_perr_odd", 32'(x_perr[s3+89]), 0);
    check("pin_glitch", 32'(x_gl[sg+9]), 1);
    check("pin_majority_byte", x_byte[s5+81], 32'h66);
    check("pin_byte_5a", x_byte[s6b+81], 32'h5A);
    ndv = 0;
    for (int c = 1; c <= len; c++) ndv += int'(x_dv[c]);
    for (int c = 0; c < len; c++) begin
      RST = w_rst[c]; RX_IN = w_rx[c]; PAR_EN = w_pe[c]; PAR_TYP = w_pt[c];
      @(posedge CLK);
      #1;
    end
    RST = 1'b0; RX_IN = 1'b1;
    @(negedge CLK);
    #1;
    check("dv_pulse_count", dut_dv, ndv);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It detects the start bit, runs the per-bit oversampling edge counter and the bit counter, and majority-samples RX_IN. It drives the deserializer's Enable/Sbit/edg_cnt inputs and checks the start, parity and stop bits. It flags a good frame with a one-cycle data_valid, at which point the deserializer's P_DATA holds the received byte.

Parameters:
DATA_WIDTH, 8, data bits per frame (LSB first).
COUNTER_WIDTH, 3, edge-counter width. Prescale = 2^COUNTER_WIDTH clocks per bit; must be >= 3.
BIT_CNT_WIDTH, 4, bit-counter width. Must satisfy 2^BIT_CNT_WIDTH > DATA_WIDTH.

Ports:
CLK  input  1  clock.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line, idle high; already synchronised to CLK.
PAR_EN  input  1  parity bit present; sampled at frame start.
PAR_TYP  input  1  0 = even, 1 = odd; sampled at frame start.
edg_cnt  output  COUNTER_WIDTH  oversampling edge count within the current bit.
bit_cnt  output  BIT_CNT_WIDTH  data-bit index during DATA; 0 otherwise.
deser_en  output  1  deserializer Enable; high throughout DATA state.
sampled_bit  output  1  majority-voted bit value; deserializer Sbit.
par_err  output  1  parity mismatch on the last frame.
stp_err  output  1  stop bit sampled low on the last frame.
strt_glitch  output  1  one-cycle pulse: false start bit.
data_valid  output  1  one-cycle pulse: frame received without error.

Behaviour:
- Definitions: cnt_max = 2^COUNTER_WIDTH - 1; mid = 2^(COUNTER_WIDTH-1).
- Reset:
  - When RST = 1 at a CLK edge: state = IDLE, all outputs 0 except sampled_bit = 1, latched parity config = 0.
  - Reset mid-frame aborts the frame immediately. No data_valid or error pulse is produced.
- Edge counter:
  - Held at 0 in IDLE.
  - In every other state it increments each clock and wraps cnt_max -> 0.
- Sampling:
  - RX_IN is captured at edg_cnt = mid-1, mid and mid+1 (3, 4, 5 for the default).
  - sampled_bit registers the 2-of-3 majority on the clock ending edg_cnt = mid+1.
  - sampled_bit is stable from edg_cnt = mid+2 through cnt_max. All end-of-bit decisions use it at edg_cnt = cnt_max.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, RX_IN = 0: go to START with edg_cnt = 0. Latch PAR_EN/PAR_TYP. Clear par_err, stp_err and the parity accumulator.
  - START, edg_cnt = cnt_max:
    - sampled_bit = 1: pulse strt_glitch for 1 cycle and return to IDLE.
    - otherwise: go to DATA with bit_cnt = 0.
  - DATA: deser_en = 1. At edg_cnt = cnt_max:
    - accumulator ^= sampled_bit;
    - if bit_cnt = DATA_WIDTH-1, go to PARITY (latched PAR_EN = 1) or STOP (PAR_EN = 0);
    - else bit_cnt++.
    - The deserializer shifts on the same edge, so exactly DATA_WIDTH shifts occur per frame.
  - PARITY, edg_cnt = cnt_max: par_err <= sampled_bit XOR (accumulator XOR latched PAR_TYP); go to STOP.
  - STOP, edg_cnt = cnt_max:
    - stp_err <= ~sampled_bit;
    - if (~par_err & sampled_bit), data_valid pulses in the next cycle;
    - go to IDLE.
- bit_cnt resets to 0 on leaving DATA.
- par_err and stp_err hold their value until the next start detection.
- Back-to-back frames: RX_IN low in the first IDLE cycle after STOP starts the next frame. That cycle may coincide with the data_valid pulse.
- Latency (defaults, parity on): start-detect cycle + 11 x 8 bit periods. data_valid occurs 89 clocks after the first clock at which IDLE sees RX_IN = 0.
- PAR_EN/PAR_TYP changes mid-frame have no effect.

Test Plan:
1. PAR_EN = 0, frame 0xA5 (LSB first), stop = 1 -> deser_en high for exactly 64 clocks; data_valid single pulse; deserializer P_DATA = 0xA5; par_err = stp_err = 0.
2. PAR_EN = 1, PAR_TYP = 0, data 0x3C, parity bit 0 -> data_valid pulse, par_err = 0. Repeat with parity bit 1 -> par_err = 1, no data_valid.
3. PAR_EN = 1, PAR_TYP = 1, data 0x01, parity bit 0, stop bit driven 0 -> stp_err = 1, par_err = 0, no data_valid; FSM returns to IDLE.
4. RX_IN low for 2 clocks then high -> strt_glitch pulse at start-bit edg_cnt = 7; no deser_en; IDLE afterwards.
5. Data bit 1 with RX_IN forced low only at edg_cnt = 4 -> sampled_bit = 1 (majority); received byte unaffected.
6. RST = 1 during DATA bit 3 -> next cycle state IDLE, edg_cnt = bit_cnt = 0, deser_en = 0. A clean 0x5A frame afterwards -> data_valid, P_DATA = 0x5A.
